dtree_feature_sequencer: RTL and testbench
==========================================

# dtree_feature_sequencer

Sequential front/back end for the combinational printed decision-tree classifiers. Accepts a byte-serial feature stream, assembles it into the parallel feature vector the tree consumes, and holds that vector stable for a programmable settle time to cover slow printed-logic propagation. It then captures the tree's class output and returns it over a valid/ready result interface. The block sits between the sensor/host byte link and one `top`-style classifier instance.

## Interface
Parameters:
- `N_FEAT`, 7: features per frame (≥2).
- `FEAT_W`, 8: feature width in bits (two's-complement, passed through untouched).
- `CLASS_W`, 5: classifier output width.
- `SETTLE_CYC`, 2: cycles the vector is held before class capture (≥1).
- `CNT_W`, 16: width of the good-frame counter.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: feature byte valid.
- `in_ready` out 1: block accepts a byte this cycle.
- `in_data` in `FEAT_W`: feature byte.
- `in_last` in 1: marks the final byte of a frame.
- `feat_flat` out `N_FEAT*FEAT_W`: vector to the classifier. Feature k is at `[k*FEAT_W +: FEAT_W]`, and feature 0 is the first byte of the frame.
- `cls_in` in `CLASS_W`: classifier output (combinational from `feat_flat`).
- `out_valid` out 1: result available.
- `out_ready` in 1: result consumer ready.
- `out_class` out `CLASS_W`: captured class.
- `err_len` out 1: one-cycle pulse on a malformed frame.
- `frames_ok` out `CNT_W`: saturating count of frames classified.

## Operation
- States: LOAD, DRAIN, SETTLE, OUT.
- LOAD:
  - `in_ready`=1. A byte is accepted when `in_valid`=1; it is written to slot `idx`, then `idx`++.
  - Accepted byte with `idx`<N_FEAT-1 and `in_last`=1 is a short frame. Pulse `err_len`, set `idx`←0, stay in LOAD. Slots already written keep their new values.
  - Accepted byte with `idx`=N_FEAT-1 and `in_last`=1: go to SETTLE, `idx`←0, settle counter←SETTLE_CYC-1.
  - Accepted byte with `idx`=N_FEAT-1 and `in_last`=0 is a long frame. Pulse `err_len`, `idx`←0, go to DRAIN.
- DRAIN:
  - `in_ready`=1. Accepted bytes are discarded and do not write `feat_flat`.
  - The accepted byte with `in_last`=1 returns the block to LOAD. No second `err_len` pulse.
- SETTLE:
  - `in_ready`=0. The counter decrements each cycle.
  - In the cycle the counter is 0: `out_class`←`cls_in`, `frames_ok`++ (saturates at all-ones), go to OUT.
- OUT:
  - `out_valid`=1. `out_class` is held stable.
  - When `out_ready`=1, go to LOAD.
  - `in_ready` stays 0 for that whole cycle; there is no same-cycle bypass.
- `feat_flat` changes only on accepted LOAD bytes. It is held through SETTLE and OUT.
- `err_len` is registered.

## Timing
- Reset values: state LOAD, `idx`=0, `feat_flat`=0, `out_class`=0, `out_valid`=0, `err_len`=0, `frames_ok`=0. `in_ready`=1 in the first cycle after reset.
- `in_ready` and `out_valid` are decoded from registered state only. They have no combinational path from `in_valid` or `out_ready`.
- Latency: last byte accepted in cycle t → SETTLE occupies t+1..t+SETTLE_CYC → `out_valid`=1 from t+SETTLE_CYC+1.
- Minimum frame period: N_FEAT+SETTLE_CYC+1 cycles with `out_ready` held high.
- `err_len` is high for exactly the cycle after the offending byte is accepted.
- Reset asserted in any state returns to reset values on the next edge. A partial frame or pending result is discarded.
- `in_valid` asserted in SETTLE/OUT is ignored (no acceptance). The upstream producer holds the byte.

## Structure
- Package `dtree_pkg`:
  - state enum `dtree_seq_state_t` {LOAD, DRAIN, SETTLE, OUT};
  - default constants `DT_N_FEAT`, `DT_FEAT_W`, `DT_CLASS_W`.
- The classifier is not instantiated inside this block. The integration wrapper connects `feat_flat` slices and `cls_in` to it.
- There is no sub-module. Counter, index and FSM are a single module.

## Test plan
- Nominal: reset; send 7 bytes 0x10..0x16 with `in_last` on 0x16; `cls_in` tied to 5'd19; `out_ready`=1 → `feat_flat`=0x16151413121110, `out_valid` high exactly 3 cycles after the last acceptance, `out_class`=19, `frames_ok`=1.
- Backpressure: `out_ready`=0 for 10 cycles after `out_valid` → `out_class` and `feat_flat` stable, `in_ready`=0; release → `in_ready`=1 next cycle.
- Short frame: `in_last` on the 4th byte → single `err_len` pulse, no `out_valid`, `frames_ok` unchanged; next full frame classifies correctly.
- Long frame: 9 bytes with `in_last` on the 9th → `err_len` pulses once after byte 7; bytes 8–9 are dropped and `feat_flat` holds bytes 1–7; no result is produced.
- Counter saturation: `CNT_W`=2, send 5 good frames → `frames_ok` reads 1,2,3,3,3.
- Reset mid-SETTLE: assert `rst` one cycle into SETTLE → all outputs return to reset values, no `out_valid`, `in_ready`=1 after release.

Source files
------------

// File: rtl/dtree_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dtree_pkg
//  Description : Shared types and default sizing for the decision-tree
//                feature sequencer.
//                  dtree_seq_state_t : sequencer state encoding
//                  DT_N_FEAT         : default features per frame
//                  DT_FEAT_W         : default feature width
//                  DT_CLASS_W        : default classifier output width
//  Revision    : 1.0 - initial release
// ============================================================================
package dtree_pkg;

    localparam int DT_N_FEAT  = 7;
    localparam int DT_FEAT_W  = 8;
    localparam int DT_CLASS_W = 5;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DRAIN  = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } dtree_seq_state_t;

endpackage : dtree_pkg
`default_nettype wire

// File: rtl/dtree_feature_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : dtree_feature_sequencer
//  Description : Byte-serial front end / result back end for a combinational
//                printed decision-tree classifier. Assembles a frame of
//                N_FEAT feature bytes into feat_flat, holds it for SETTLE_CYC
//                cycles while the tree settles, captures cls_in and offers it
//                on a valid/ready result port.
//  Ports       :
//      clk, rst            clock, synchronous active-high reset
//      in_valid/in_ready   feature byte handshake
//      in_data, in_last    feature byte, end-of-frame marker
//      feat_flat           parallel feature vector (feature 0 = first byte)
//      cls_in              classifier output
//      out_valid/out_ready result handshake
//      out_class           captured class
//      err_len             one-cycle pulse on a short or long frame
//      frames_ok           saturating count of classified frames
//  Revision    : 1.0 - initial release
// ============================================================================
module dtree_feature_sequencer
    import dtree_pkg::*;
#(
    parameter int N_FEAT     = DT_N_FEAT,
    parameter int FEAT_W     = DT_FEAT_W,
    parameter int CLASS_W    = DT_CLASS_W,
    parameter int SETTLE_CYC = 2,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FEAT_W-1:0]        in_data,
    input  logic                     in_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_flat,
    input  logic [CLASS_W-1:0]       cls_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     err_len,
    output logic [CNT_W-1:0]         frames_ok
);

    localparam int IDX_W = $clog2(N_FEAT);
    // The settle counter only has to hold SETTLE_CYC-1.
    localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    dtree_seq_state_t        r_state;
    logic [IDX_W-1:0]        r_idx;
    logic [SCNT_W-1:0]       r_scnt;
    logic [N_FEAT*FEAT_W-1:0] r_feat;
    logic [CLASS_W-1:0]      r_class;
    logic                    r_err;
    logic [CNT_W-1:0]        r_frames;

    logic                    w_idx_last;

    assign w_idx_last = (r_idx == IDX_W'(N_FEAT - 1));

    // Handshake outputs depend on registered state only.
    assign in_ready  = (r_state == LOAD) || (r_state == DRAIN);
    assign out_valid = (r_state == OUT);

    assign feat_flat = r_feat;
    assign out_class = r_class;
    assign err_len   = r_err;
    assign frames_ok = r_frames;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD;
            r_idx    <= '0;
            r_scnt   <= '0;
            r_feat   <= '0;
            r_class  <= '0;
            r_err    <= 1'b0;
            r_frames <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                LOAD: begin
                    if (in_valid) begin
                        for (int k = 0; k < N_FEAT; k++) begin
                            if (r_idx == IDX_W'(k)) begin
                                r_feat[k*FEAT_W +: FEAT_W] <= in_data;
                            end
                        end
                        if (w_idx_last) begin
                            r_idx <= '0;
                            if (in_last) begin
                                r_state <= SETTLE;
                                r_scnt  <= SCNT_W'(SETTLE_CYC - 1);
                            end else begin
                                // Too many bytes: flag once, then swallow the
                                // rest of the frame without touching feat_flat.
                                r_err   <= 1'b1;
                                r_state <= DRAIN;
                            end
                        end else if (in_last) begin
                            // Short frame: partial writes are kept, restart.
                            r_err <= 1'b1;
                            r_idx <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (in_valid && in_last) begin
                        r_state <= LOAD;
                    end
                end
                SETTLE: begin
                    if (r_scnt == '0) begin
                        r_class <= cls_in;
                        if (r_frames != '1) begin
                            r_frames <= r_frames + 1'b1;
                        end
                        r_state <= OUT;
                    end else begin
                        r_scnt <= r_scnt - 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_state <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

endmodule : dtree_feature_sequencer
`default_nettype wire

// File: tb/tb_dtree_feature_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dtree_feature_sequencer
//  Description : Directed bench for dtree_feature_sequencer. A frame table
//                drives nominal, short, long and saturating-counter traffic
//                into two instances (CNT_W=16 and CNT_W=2) sharing the same
//                stimulus, followed by a reset-during-SETTLE sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dtree_feature_sequencer;

    localparam int N_FEAT  = 7;
    localparam int FEAT_W  = 8;
    localparam int CLASS_W = 5;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic [FEAT_W-1:0]        in_data;
    logic                     in_last;
    logic [CLASS_W-1:0]       cls_in;
    logic                     out_ready;

    logic                     in_ready;
    logic [N_FEAT*FEAT_W-1:0] feat_flat;
    logic                     out_valid;
    logic [CLASS_W-1:0]       out_class;
    logic                     err_len;
    logic [15:0]              frames_ok;

    logic                     b_in_ready;
    logic [N_FEAT*FEAT_W-1:0] b_feat_flat;
    logic                     b_out_valid;
    logic [CLASS_W-1:0]       b_out_class;
    logic                     b_err_len;
    logic [1:0]               b_frames_ok;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dtree_feature_sequencer #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
        .SETTLE_CYC(2), .CNT_W(16)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .feat_flat(feat_flat), .cls_in(cls_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .err_len(err_len),
        .frames_ok(frames_ok)
    );

    dtree_feature_sequencer #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W),
        .SETTLE_CYC(2), .CNT_W(2)
    ) u_dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last),
        .feat_flat(b_feat_flat), .cls_in(cls_in),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_class(b_out_class), .err_len(b_err_len),
        .frames_ok(b_frames_ok)
    );

    typedef struct {
        int               nbytes;      // bytes sent
        logic [7:0]       base;        // byte i = base + i
        int               err_at;      // byte index whose acceptance flags err_len, -1 none
        logic             result;      // frame is classified
        logic [4:0]       cls;         // classifier output presented
        int               hold;        // cycles out_ready held low once out_valid
        logic [55:0]      exp_feat;
        logic [15:0]      exp_frames;
        logic [1:0]       exp_frames_sat;
    } frame_t;

    frame_t frames [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input frame_t f);
        cls_in    = f.cls;
        out_ready = 1'b0;
        for (int i = 0; i < f.nbytes; i++) begin
            in_valid = 1'b1;
            in_data  = f.base + 8'(i);
            in_last  = (i == f.nbytes - 1);
            check("in_ready_during_frame", 64'(in_ready), 64'd1);
            step();
            check("err_len_timing", 64'(err_len), (i == f.err_at) ? 64'd1 : 64'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (f.result) begin
            // t+1 and t+2 are SETTLE, result visible from t+3
            check("in_ready_settle", 64'(in_ready), 64'd0);
            check("out_valid_t1", 64'(out_valid), 64'd0);
            step();
            check("out_valid_t2", 64'(out_valid), 64'd0);
            step();
            check("out_valid_t3", 64'(out_valid), 64'd1);
            check("out_class", 64'(out_class), 64'(f.cls));
            check("feat_flat", 64'(feat_flat), 64'(f.exp_feat));
            check("frames_ok", 64'(frames_ok), 64'(f.exp_frames));
            check("frames_ok_sat", 64'(b_frames_ok), 64'(f.exp_frames_sat));
            // Backpressure: a different class and an offered byte must be ignored.
            cls_in   = ~f.cls;
            in_valid = 1'b1;
            in_data  = 8'hEE;
            for (int c = 0; c < f.hold; c++) begin
                step();
                check("hold_out_valid", 64'(out_valid), 64'd1);
                check("hold_in_ready", 64'(in_ready), 64'd0);
                check("hold_out_class", 64'(out_class), 64'(f.cls));
                check("hold_feat_flat", 64'(feat_flat), 64'(f.exp_feat));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("in_ready_release_cycle", 64'(in_ready), 64'd0);
            step();
            out_ready = 1'b0;
            check("in_ready_after_release", 64'(in_ready), 64'd1);
            check("out_valid_after_release", 64'(out_valid), 64'd0);
        end else begin
            for (int c = 0; c < 4; c++) begin
                check("noresult_in_ready", 64'(in_ready), 64'd1);
                step();
                check("noresult_out_valid", 64'(out_valid), 64'd0);
                check("noresult_err_len", 64'(err_len), 64'd0);
            end
            check("noresult_feat_flat", 64'(feat_flat), 64'(f.exp_feat));
            check("noresult_frames_ok", 64'(frames_ok), 64'(f.exp_frames));
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_feat_flat"}, 64'(feat_flat), 64'd0);
        check({tag, "_out_class"}, 64'(out_class), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_err_len"}, 64'(err_len), 64'd0);
        check({tag, "_frames_ok"}, 64'(frames_ok), 64'd0);
        check({tag, "_frames_ok_sat"}, 64'(b_frames_ok), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        frames[0] = '{7, 8'h10, -1, 1'b1, 5'd19, 10, 56'h16151413121110, 16'd1, 2'd1};
        frames[1] = '{4, 8'h20,  3, 1'b0, 5'd0,   0, 56'h16151423222120, 16'd1, 2'd1};
        frames[2] = '{7, 8'h30, -1, 1'b1, 5'd7,   2, 56'h36353433323130, 16'd2, 2'd2};
        frames[3] = '{9, 8'h40,  6, 1'b0, 5'd0,   0, 56'h46454443424140, 16'd2, 2'd2};
        frames[4] = '{7, 8'h50, -1, 1'b1, 5'd31,  0, 56'h56555453525150, 16'd3, 2'd3};
        frames[5] = '{7, 8'h60, -1, 1'b1, 5'd0,   1, 56'h66656463626160, 16'd4, 2'd3};
        frames[6] = '{7, 8'h70, -1, 1'b1, 5'd12,  0, 56'h76757473727170, 16'd5, 2'd3};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        cls_in    = '0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_reset_values("reset");
        step();
        check("idle_in_ready", 64'(in_ready), 64'd1);

        for (int f = 0; f < 7; f++) begin
            send_frame(frames[f]);
        end

        // Reset one cycle into SETTLE discards the pending result.
        cls_in = 5'd9;
        for (int i = 0; i < N_FEAT; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h80 + 8'(i);
            in_last  = (i == N_FEAT - 1);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("midsettle_in_ready", 64'(in_ready), 64'd0);
        rst = 1'b1;
        step();
        check_reset_values("midsettle_rst");
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            check("post_rst_out_valid", 64'(out_valid), 64'd0);
            check("post_rst_in_ready", 64'(in_ready), 64'd1);
        end
        send_frame('{7, 8'h90, -1, 1'b1, 5'd3, 0, 56'h96959493929190, 16'd1, 2'd1});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dtree_feature_sequencer
`default_nettype wire
